// File: rtl/hack_boot_loader_if.sv
// Byte-stream, instruction-ROM write and CPU control signals of the Hack boot loader.
// The slave modport is the loader's view; the master modport is the surrounding
// system (host link, ROM, CPU) as seen from the outside.
interface hack_boot_loader_if #(
  parameter int ROM_AW = 15
);
  logic              boot_req;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ROM_AW:0]   words_loaded;

  modport master (
    output boot_req, rx_data, rx_valid,
    input  rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error, words_loaded
  );

  modport slave (
    input  boot_req, rx_data, rx_valid,
    output rx_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error, words_loaded
  );
endinterface

// File: rtl/hack_boot_loader.sv
// Hack CPU boot loader: receives a length-prefixed, big-endian image over an 8-bit
// valid/ready byte stream, writes it into instruction ROM from address 0, checks the
// trailing modulo-256 checksum and only then releases the CPU from reset.
// Optional build macro HACK_BOOT_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CYCLES clocks in every loading state except LEN_HI.
// ROM_AW must match the interface parameter and be at most 16.
module hack_boot_loader #(
  parameter int ROM_AW         = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  hack_boot_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_e;

  // Largest image that fits the ROM, in words.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ROM_AW;

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        data_hi_q, data_hi_d;
  logic [7:0]        acc_q, acc_d;
  logic [ROM_AW:0]   words_q, words_d;
  logic              rom_we_q, rom_we_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_wdata_q, rom_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              rx_ready;
  logic              accept;
  logic              timeout_hit;
  logic [16:0]       len_full;
  logic [ROM_AW:0]   words_inc;

  assign rx_ready  = (state_q != S_RUN) && (state_q != S_ERROR);
  assign accept    = bus.rx_valid && rx_ready;
  assign len_full  = {1'b0, len_hi_q, bus.rx_data};
  assign words_inc = words_q + (ROM_AW+1)'(1);

`ifdef HACK_BOOT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_q, to_d;
  logic            timed;

  assign timed = (state_q == S_LEN_LO) || (state_q == S_DATA_HI) ||
                 (state_q == S_DATA_LO) || (state_q == S_CSUM);

  // Idle-cycle counter: restarts on every accepted byte and outside the timed states.
  always_comb begin
    to_d        = to_q;
    timeout_hit = 1'b0;
    if (!timed || accept) begin
      to_d = '0;
    end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      timeout_hit = 1'b1;
      to_d        = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and output decode: bytes advance the frame parser, DATA_LO bytes
  // schedule a ROM write for the following cycle.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    data_hi_d   = data_hi_q;
    acc_d       = acc_q;
    words_d     = words_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = bus.rx_data;
          acc_d    = acc_q + bus.rx_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = {len_hi_q, bus.rx_data};
          acc_d = acc_q + bus.rx_data;
          if (len_full > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (len_full == 17'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          data_hi_d = bus.rx_data;
          acc_d     = acc_q + bus.rx_data;
          state_d   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = words_q[ROM_AW-1:0];
          rom_wdata_d = {data_hi_q, bus.rx_data};
          words_d     = words_inc;
          acc_d       = acc_q + bus.rx_data;
          if (17'(words_inc) == {1'b0, len_q}) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (bus.rx_data == acc_q) ? S_RUN : S_ERROR;
        end
      end
      S_RUN, S_ERROR: begin
        if (bus.boot_req) begin
          state_d = S_LEN_HI;
          words_d = '0;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    if (timeout_hit) begin
      state_d = S_ERROR;
    end

    // CPU released only once the checksum matched.
    cpu_reset_d = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERROR);
  end

  // State and output registers; reset restores the idle, CPU-held configuration.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_LEN_HI;
      len_hi_q    <= '0;
      len_q       <= '0;
      data_hi_q   <= '0;
      acc_q       <= '0;
      words_q     <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      data_hi_q   <= data_hi_d;
      acc_q       <= acc_d;
      words_q     <= words_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.rom_we       = rom_we_q;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.rom_wdata    = rom_wdata_q;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed bench for hack_boot_loader: good frame, bad checksum, zero/oversize length,
// stalled stream, mid-frame reset, ignored boot_req and the inter-byte timeout.
module tb_hack_boot_loader;
`ifdef HACK_BOOT_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hack_boot_loader_if #(.ROM_AW(15)) bus();

  hack_boot_loader #(.ROM_AW(15), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [14:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [15:0] wn_q[$];

  logic [7:0] frame_a[$]   = '{8'h00, 8'h02, 8'h00, 8'h10, 8'hEC, 8'h10, 8'h0E};
  logic [7:0] frame_bad[$] = '{8'h00, 8'h02, 8'h00, 8'h10, 8'hEC, 8'h10, 8'h0F};
  logic [7:0] frame_b[$]   = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h47};

  // Capture every ROM write with the word count seen in the same cycle.
  always @(negedge clk) begin
    if (bus.rom_we === 1'b1) begin
      wa_q.push_back(bus.rom_addr);
      wd_q.push_back(bus.rom_wdata);
      wn_q.push_back(bus.words_loaded);
    end
  end

  // Called at a negedge; presents one byte for exactly one rising edge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit stall);
    foreach (f[i]) begin
      if (stall) begin
        int ns;
        ns = $urandom_range(0, 3);
        repeat (ns) begin
          bus.rx_valid = 1'b0;
          bus.rx_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      send_byte(f[i]);
    end
  endtask

  task automatic pulse_boot_req();
    bus.boot_req = 1'b1;
    @(negedge clk);
    bus.boot_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b expected 1", bus.cpu_reset); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b expected 1", bus.rx_ready); end
    checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("FAIL reset_rom_we: got %b expected 0", bus.rom_we); end
    checks++; if (bus.rom_addr !== 15'd0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", bus.rom_addr); end
    checks++; if (bus.rom_wdata !== 16'd0) begin errors++; $display("FAIL reset_rom_wdata: got %h expected 0", bus.rom_wdata); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.error); end
    checks++; if (bus.words_loaded !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d expected 0", bus.words_loaded); end
    rst = 1'b0;
  endtask

  task automatic test_load(input bit stall, input string tag);
    wa_q.delete(); wd_q.delete(); wn_q.delete();
    send_frame(frame_a[0:5], stall);
    checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL %s_cpu_held: got %b expected 1", tag, bus.cpu_reset); end
    send_frame(frame_a[6:6], stall);
    checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL %s_write_count: got %0d expected 2", tag, wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 15'd0 || wd_q[0] !== 16'h0010 || wn_q[0] !== 16'd1) begin errors++; $display("FAIL %s_write0: got addr %h data %h words %0d expected 0000 0010 1", tag, wa_q[0], wd_q[0], wn_q[0]); end
      checks++; if (wa_q[1] !== 15'd1 || wd_q[1] !== 16'hEC10 || wn_q[1] !== 16'd2) begin errors++; $display("FAIL %s_write1: got addr %h data %h words %0d expected 0001 ec10 2", tag, wa_q[1], wd_q[1], wn_q[1]); end
    end
    checks++; if (bus.words_loaded !== 16'd2) begin errors++; $display("FAIL %s_words: got %0d expected 2", tag, bus.words_loaded); end
    checks++; if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL %s_run: got done %b cpu_reset %b expected 1 0", tag, bus.done, bus.cpu_reset); end
    checks++; if (bus.rx_ready !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL %s_run_flags: got rx_ready %b error %b expected 0 0", tag, bus.rx_ready, bus.error); end
  endtask

  task automatic test_bad_checksum();
    pulse_boot_req();
    checks++; if (bus.done !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.rx_ready !== 1'b1 || bus.words_loaded !== 16'd0) begin errors++; $display("FAIL reboot: got done %b cpu_reset %b rx_ready %b words %0d expected 0 1 1 0", bus.done, bus.cpu_reset, bus.rx_ready, bus.words_loaded); end
    wa_q.delete(); wd_q.delete(); wn_q.delete();
    send_frame(frame_bad, 1'b0);
    checks++; if (wa_q.size() !== 2 || wd_q[0] !== 16'h0010 || wd_q[1] !== 16'hEC10) begin errors++; $display("FAIL badcs_writes: got %0d writes expected 2 of 0010 ec10", wa_q.size()); end
    checks++; if (bus.error !== 1'b1 || bus.cpu_reset !== 1'b1 || bus.rx_ready !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL badcs_state: got error %b cpu_reset %b rx_ready %b done %b expected 1 1 0 0", bus.error, bus.cpu_reset, bus.rx_ready, bus.done); end
    pulse_boot_req();
    checks++; if (bus.error !== 1'b0 || bus.rx_ready !== 1'b1 || bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL badcs_restart: got error %b rx_ready %b cpu_reset %b expected 0 1 1", bus.error, bus.rx_ready, bus.cpu_reset); end
  endtask

  task automatic test_length_bounds();
    wa_q.delete();
    send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL zero_len_writes: got %0d expected 0", wa_q.size()); end
    checks++; if (bus.done !== 1'b1 || bus.words_loaded !== 16'd0) begin errors++; $display("FAIL zero_len_done: got done %b words %0d expected 1 0", bus.done, bus.words_loaded); end
    pulse_boot_req();
    send_frame('{8'h80, 8'h01}, 1'b0);
    checks++; if (bus.error !== 1'b1 || bus.rx_ready !== 1'b0) begin errors++; $display("FAIL oversize_len: got error %b rx_ready %b expected 1 0", bus.error, bus.rx_ready); end
    pulse_boot_req();
    send_frame('{8'h80, 8'h00}, 1'b0);
    checks++; if (bus.error !== 1'b0 || bus.rx_ready !== 1'b1) begin errors++; $display("FAIL max_len_accepted: got error %b rx_ready %b expected 0 1", bus.error, bus.rx_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mid_reset();
    pulse_boot_req();
    send_frame(frame_a[0:4], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.rom_we !== 1'b0 || bus.rom_addr !== 15'd0 || bus.rom_wdata !== 16'd0) begin errors++; $display("FAIL midrst_rom: got we %b addr %h data %h expected 0 0 0", bus.rom_we, bus.rom_addr, bus.rom_wdata); end
    checks++; if (bus.words_loaded !== 16'd0 || bus.cpu_reset !== 1'b1 || bus.rx_ready !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got words %0d cpu_reset %b rx_ready %b done %b error %b expected 0 1 1 0 0", bus.words_loaded, bus.cpu_reset, bus.rx_ready, bus.done, bus.error); end
    wa_q.delete(); wd_q.delete();
    send_frame(frame_b, 1'b0);
    checks++; if (wa_q.size() !== 1 || wa_q[0] !== 15'd0 || wd_q[0] !== 16'h1234) begin errors++; $display("FAIL midrst_reload: got %0d writes expected one 0000=1234", wa_q.size()); end
    checks++; if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL midrst_run: got done %b cpu_reset %b expected 1 0", bus.done, bus.cpu_reset); end
  endtask

  task automatic test_boot_req_ignored();
    pulse_boot_req();
    wa_q.delete(); wd_q.delete();
    send_frame(frame_b[0:1], 1'b0);
    pulse_boot_req();
    send_frame(frame_b[2:4], 1'b0);
    checks++; if (wa_q.size() !== 1 || wd_q[0] !== 16'h1234) begin errors++; $display("FAIL bootreq_ignored_write: got %0d writes expected one 1234", wa_q.size()); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bootreq_ignored_done: got %b expected 1", bus.done); end
  endtask

  task automatic test_timeout();
    pulse_boot_req();
    send_frame('{8'h00, 8'h02}, 1'b0);
`ifdef HACK_BOOT_TIMEOUT_EN
    begin
      int k;
      k = 0;
      for (int c = 1; c <= 100 && k == 0; c++) begin
        @(negedge clk);
        if (bus.error === 1'b1) k = c;
      end
      checks++; if (k !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d expected 16", k); end
    end
`else
    repeat (1000) @(negedge clk);
    checks++; if (bus.error !== 1'b0 || bus.rx_ready !== 1'b1) begin errors++; $display("FAIL no_timeout: got error %b rx_ready %b expected 0 1", bus.error, bus.rx_ready); end
    wa_q.delete(); wd_q.delete();
    send_frame('{8'h00, 8'h10}, 1'b0);
    @(negedge clk);
    checks++; if (wa_q.size() !== 1 || wd_q[0] !== 16'h0010) begin errors++; $display("FAIL no_timeout_still_data_hi: got %0d writes expected one 0010", wa_q.size()); end
`endif
  endtask

  initial begin
    bus.boot_req = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_load(1'b0, "load");
    test_bad_checksum();
    test_length_bounds();
    test_load(1'b1, "stall");
    test_mid_reset();
    test_boot_req_ignored();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
